// File: rtl/gbsha_decim_acc.sv
// Decimating integrate-and-dump stage behind the 2-tap difference FIR.
// Sums DECIM accepted samples, scales and clamps each window, and holds the result in a one-deep valid/ready register.
module gbsha_decim_acc #(
  parameter int BW_in  = 3,
  parameter int DECIM  = 4,
  parameter int BW_acc = BW_in + $clog2(DECIM),
  parameter int SHIFT  = 0,
  parameter int BW_out = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [BW_in-1:0]    in_data,
  input  logic                       clear,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [BW_out-1:0]   out_data,
  output logic                       sat,
  output logic                       overflow,
  output logic [$clog2(DECIM)-1:0]   phase
);

  localparam int PW = $clog2(DECIM);
  // One guard bit above the wider of accumulator/output keeps the clamp compare exact.
  localparam int CW = ((BW_acc > BW_out) ? BW_acc : BW_out) + 1;
  localparam logic signed [CW-1:0] OUT_MAX = CW'((1 <<< (BW_out - 1)) - 1);
  localparam logic signed [CW-1:0] OUT_MIN = CW'(-(1 <<< (BW_out - 1)));

  logic signed [BW_acc-1:0] acc_reg;
  logic signed [CW-1:0]     sum_next;
  logic signed [CW-1:0]     shifted_next;
  logic signed [BW_out-1:0] value_next;
  logic                     sat_next;
  logic                     dump;
  logic                     out_free;

  always_comb begin
    sum_next     = CW'(acc_reg) + CW'(in_data);
    shifted_next = sum_next >>> SHIFT;
    sat_next     = 1'b0;
    value_next   = shifted_next[BW_out-1:0];
    if (shifted_next > OUT_MAX) begin
      value_next = OUT_MAX[BW_out-1:0];
      sat_next   = 1'b1;
    end else if (shifted_next < OUT_MIN) begin
      value_next = OUT_MIN[BW_out-1:0];
      sat_next   = 1'b1;
    end
  end

  assign dump     = in_valid && (phase == PW'(DECIM - 1));
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg   <= '0;
      phase     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sat       <= 1'b0;
      overflow  <= 1'b0;
    end else if (clear) begin
      // out_data is left as-is; only the valid/sat/overflow qualifiers restart.
      acc_reg   <= '0;
      phase     <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (dump) begin
        acc_reg <= '0;
        phase   <= '0;
        if (out_free) begin
          out_data  <= value_next;
          sat       <= sat_next;
          out_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else begin
        if (in_valid) begin
          acc_reg <= sum_next[BW_acc-1:0];
          phase   <= phase + PW'(1);
        end
        if (out_valid && out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_gbsha_decim_acc.sv
// Directed bench for gbsha_decim_acc: two instances (SHIFT=0 and SHIFT=1) checked against a window-level model every cycle.
module tb_gbsha_decim_acc;

  localparam int DECIM = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [2:0] in_data = '0;
  logic              clear = 1'b0;
  logic              out_ready = 1'b0;

  logic              ov0, ov1, st0, st1, of0, of1;
  logic signed [3:0] od0, od1;
  logic [1:0]        ph0, ph1;

  int checks = 0;
  int failures = 0;

  // Model state per instance: running window sum/count and the output register contents.
  int m_sum[2];
  int m_cnt[2];
  int m_data[2];
  int m_valid[2];
  int m_sat[2];
  int m_ovf[2];

  always #5 clk = ~clk;

  gbsha_decim_acc #(.BW_in(3), .DECIM(DECIM), .SHIFT(0), .BW_out(4)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_ready(out_ready), .out_valid(ov0), .out_data(od0), .sat(st0), .overflow(of0), .phase(ph0)
  );

  gbsha_decim_acc #(.BW_in(3), .DECIM(DECIM), .SHIFT(1), .BW_out(4)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .out_ready(out_ready), .out_valid(ov1), .out_data(od1), .sat(st1), .overflow(of1), .phase(ph1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic scale(input int sum, input int sh, output int v, output int s);
    int r;
    r = sum >>> sh;
    s = 0;
    v = r;
    if (r > 7) begin v = 7; s = 1; end
    if (r < -8) begin v = -8; s = 1; end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        m_sum[k] = 0; m_cnt[k] = 0; m_data[k] = 0;
        m_valid[k] = 0; m_sat[k] = 0; m_ovf[k] = 0;
      end
    end else if (clear) begin
      for (int k = 0; k < 2; k++) begin
        m_sum[k] = 0; m_cnt[k] = 0;
        m_valid[k] = 0; m_sat[k] = 0; m_ovf[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int  v, s;
        bit  free, dumped;
        free   = (m_valid[k] == 0) || out_ready;
        dumped = 1'b0;
        if (in_valid) begin
          m_sum[k] += int'(in_data);
          m_cnt[k] += 1;
          if (m_cnt[k] == DECIM) begin
            scale(m_sum[k], k, v, s);
            m_sum[k] = 0;
            m_cnt[k] = 0;
            dumped   = 1'b1;
            if (free) begin
              m_data[k] = v; m_sat[k] = s; m_valid[k] = 1;
            end else begin
              m_ovf[k] = 1;
            end
          end
        end
        if (!dumped && m_valid[k] == 1 && out_ready) m_valid[k] = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("u0_out_valid", int'(ov0), m_valid[0]);
    chk("u0_out_data", int'(od0), m_data[0]);
    chk("u0_sat", int'(st0), m_sat[0]);
    chk("u0_overflow", int'(of0), m_ovf[0]);
    chk("u0_phase", int'(ph0), m_cnt[0]);
    chk("u1_out_valid", int'(ov1), m_valid[1]);
    chk("u1_out_data", int'(od1), m_data[1]);
    chk("u1_sat", int'(st1), m_sat[1]);
    chk("u1_overflow", int'(of1), m_ovf[1]);
    chk("u1_phase", int'(ph1), m_cnt[1]);
  end

  task automatic cyc(input logic v, input int d, input logic rdy, input logic clr);
    in_valid  = v;
    in_data   = 3'(d);
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    #1;
    $display("cyc v=%0d d=%0d rdy=%0d clr=%0d | u0 valid=%0d data=%0d sat=%0d ovf=%0d phase=%0d | u1 data=%0d sat=%0d",
             v, d, rdy, clr, ov0, od0, st0, of0, ph0, od1, st1);
  endtask

  task automatic win(input int a, input int b, input int c, input int d, input logic rdy);
    cyc(1'b1, a, rdy, 1'b0);
    cyc(1'b1, b, rdy, 1'b0);
    cyc(1'b1, c, rdy, 1'b0);
    cyc(1'b1, d, rdy, 1'b0);
  endtask

  task automatic lit0(input string nm, input int valid, input int data, input int s, input int ovf, input int ph);
    chk({nm, "_valid"}, int'(ov0), valid);
    chk({nm, "_data"}, int'(od0), data);
    chk({nm, "_sat"}, int'(st0), s);
    chk({nm, "_ovf"}, int'(of0), ovf);
    chk({nm, "_phase"}, int'(ph0), ph);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    lit0("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Reset mid-window, then a clean window of ones.
    cyc(1'b1, 1, 1'b1, 1'b0);
    cyc(1'b1, 1, 1'b1, 1'b0);
    chk("t1_phase_before_reset", int'(ph0), 2);
    #2 reset = 1'b1;
    #1 lit0("t1_async_reset", 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    cyc(1'b1, 1, 1'b1, 1'b0);
    cyc(1'b1, 1, 1'b1, 1'b0);
    cyc(1'b1, 1, 1'b1, 1'b0);
    chk("t1_not_yet_valid", int'(ov0), 0);
    cyc(1'b1, 1, 1'b1, 1'b0);
    lit0("t1_result", 1, 4, 0, 0, 0);
    chk("t1_u1_data", int'(od1), 2);

    // Window with idle gaps, consumer always ready.
    cyc(1'b1, 1, 1'b1, 1'b0);
    chk("t2_phase1", int'(ph0), 1);
    chk("t2_drained", int'(ov0), 0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b1, 2, 1'b1, 1'b0);
    chk("t2_phase2", int'(ph0), 2);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b1, 3, 1'b1, 1'b0);
    chk("t2_phase3", int'(ph0), 3);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b1, -1, 1'b1, 1'b0);
    lit0("t2_result", 1, 5, 0, 0, 0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("t2_one_cycle_valid", int'(ov0), 0);
    chk("t2_data_hold", int'(od0), 5);

    // Saturation in both directions, and floor rounding with SHIFT=1.
    win(3, 3, 3, 3, 1'b1);
    lit0("t3_pos_sat", 1, 7, 1, 0, 0);
    chk("t3_u1_data_pos", int'(od1), 6);
    chk("t3_u1_sat_pos", int'(st1), 0);
    win(-4, -4, -4, -4, 1'b1);
    lit0("t3_neg_sat", 1, -8, 1, 0, 0);
    chk("t3_u1_data_neg", int'(od1), -8);
    chk("t3_u1_sat_neg", int'(st1), 0);
    win(-1, 0, 0, 0, 1'b1);
    chk("t3_u0_minus1", int'(od0), -1);
    chk("t3_u1_floor", int'(od1), -1);
    chk("t3_u1_sat_floor", int'(st1), 0);

    // Backpressure: second result is dropped and flagged.
    cyc(1'b0, 0, 1'b1, 1'b0);
    win(1, 1, 0, 0, 1'b0);
    lit0("t4_held", 1, 2, 0, 0, 0);
    win(3, 0, 0, 0, 1'b0);
    lit0("t4_dropped", 1, 2, 0, 1, 0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("t4_drain_valid", int'(ov0), 0);
    chk("t4_ovf_sticky", int'(of0), 1);

    // Clear, then a dump coinciding with the drain of a pending result.
    cyc(1'b0, 0, 1'b0, 1'b1);
    chk("t5_clear_ovf", int'(of0), 0);
    win(1, 1, 0, 0, 1'b0);
    chk("t5_pending", int'(od0), 2);
    cyc(1'b1, -1, 1'b0, 1'b0);
    cyc(1'b1, -1, 1'b0, 1'b0);
    cyc(1'b1, -1, 1'b0, 1'b0);
    cyc(1'b1, 0, 1'b1, 1'b0);
    lit0("t5_swap", 1, -3, 0, 0, 0);
    chk("t5_u1_data", int'(od1), -2);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("t5_still_valid", int'(ov0), 1);

    // Clear mid-window discards the coincident sample and the sticky flag.
    win(0, 0, 0, 0, 1'b0);
    chk("t6_ovf_set", int'(of0), 1);
    cyc(1'b1, 1, 1'b0, 1'b0);
    cyc(1'b1, 1, 1'b0, 1'b0);
    chk("t6_phase2", int'(ph0), 2);
    cyc(1'b1, 3, 1'b0, 1'b1);
    lit0("t6_cleared", 0, -3, 0, 0, 0);
    win(1, 1, 1, 1, 1'b1);
    lit0("t6_result", 1, 4, 0, 0, 0);
    cyc(1'b0, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
